// File: rtl/dense_layer_engine_if.sv
// Bundle of the dense layer engine's start/data, weight-write and result signals.
// Latency: none, wires only.
// Backpressure: none; the engine ignores starts and writes while busy is high.
// Parameters: WIDTH (word width), INPUT_SIZE (N_IN), OUTPUT_SIZE (N_OUT).
// master modport: the side that drives inputs and weights (for example an upstream layer or a bench).
// slave modport: the engine itself.
interface dense_layer_engine_if #(
    parameter int WIDTH       = 16,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 5
);
    localparam int ADDR_W = $clog2(INPUT_SIZE * OUTPUT_SIZE + OUTPUT_SIZE);

    logic                    input_ready;
    logic signed [WIDTH-1:0] input_data [INPUT_SIZE];
    logic                    w_we;
    logic [ADDR_W-1:0]       w_addr;
    logic signed [WIDTH-1:0] w_data;
    logic                    busy;
    logic                    output_ready;
    logic signed [WIDTH-1:0] output_data [OUTPUT_SIZE];

    modport master (
        output input_ready, input_data, w_we, w_addr, w_data,
        input  busy, output_ready, output_data
    );

    modport slave (
        input  input_ready, input_data, w_we, w_addr, w_data,
        output busy, output_ready, output_data
    );
endinterface

// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer: out[o] = sat(round(sum_i x[i]*w[i][o] >> NFRAC) + b[o]).
// Latency: start sampled at edge E0, output_ready/output_data valid after edge E0+INPUT_SIZE+1.
// Backpressure: none; input_ready and w_we are dropped while busy, and a new start is taken in DONE.
// Ports: clk, reset (async, active high), bus (dense_layer_engine_if.slave):
//   input_ready/input_data start a pass, w_we/w_addr/w_data load weights (i*N_OUT+o) and
//   biases (N_IN*N_OUT+o), busy/output_ready/output_data report the result.
// Optional feature: define DENSE_RELU_EN to clamp negative results to zero (fused ReLU).
module dense_layer_engine #(
    parameter int WIDTH       = 16,
    parameter int NFRAC       = 10,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 5
) (
    input  logic               clk,
    input  logic               reset,
    dense_layer_engine_if.slave bus
);
    localparam int N_IN   = INPUT_SIZE;
    localparam int N_OUT  = OUTPUT_SIZE;
    localparam int ADDR_W = $clog2(N_IN * N_OUT + N_OUT);
    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    // Accumulator wide enough for N_IN full-scale products without overflow.
    localparam int ACC_W  = 2 * WIDTH + $clog2(N_IN);
    // One extra bit so rounding offset and bias add cannot wrap before saturation.
    localparam int RW     = ACC_W + 1;

    localparam logic signed [RW-1:0] HALF  = {{(RW-1){1'b0}}, 1'b1} << (NFRAC - 1);
    localparam logic signed [RW-1:0] MAX_V = {{(RW+1-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {{(RW+1-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx;
    logic signed [WIDTH-1:0] x_lat [N_IN];
    logic signed [WIDTH-1:0] w_mem [N_IN][N_OUT];
    logic signed [WIDTH-1:0] b_mem [N_OUT];
    logic signed [WIDTH-1:0] out_q [N_OUT];
    logic signed [ACC_W-1:0] acc   [N_OUT];
    logic signed [ACC_W-1:0] prod  [N_OUT];
    logic signed [WIDTH-1:0] res   [N_OUT];
    logic                    busy_c, ready_c, start, wr_en, last;

    assign last = (idx == IDX_W'(N_IN - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.input_ready) state_nxt = MAC;
            MAC:        if (last)            state_nxt = FINAL;
            FINAL:                           state_nxt = DONE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Output / control decode; busy covers MAC and FINAL so it drops on the FINAL edge.
    always_comb begin
        busy_c  = (state == MAC) || (state == FINAL);
        ready_c = (state == DONE);
        start   = !busy_c && bus.input_ready;
        wr_en   = !busy_c && bus.w_we;
    end

    assign bus.busy         = busy_c;
    assign bus.output_ready = ready_c;
    assign bus.output_data  = out_q;

    // Per-output product, rounding, bias and saturation.
    always_comb begin
        logic signed [RW-1:0] rnd;
        logic signed [RW-1:0] sum;
        rnd = '0;
        sum = '0;
        for (int o = 0; o < N_OUT; o++) begin
            // Size casts of signed operands sign-extend, so the product is exact in ACC_W bits.
            prod[o] = ACC_W'(x_lat[idx]) * ACC_W'(w_mem[idx][o]);
            rnd     = (RW'(acc[o]) + HALF) >>> NFRAC;
            sum     = rnd + RW'(b_mem[o]);
            if (sum > MAX_V)      res[o] = MAX_V[WIDTH-1:0];
            else if (sum < MIN_V) res[o] = MIN_V[WIDTH-1:0];
            else                  res[o] = sum[WIDTH-1:0];
`ifdef DENSE_RELU_EN
            if (res[o][WIDTH-1]) res[o] = '0;
`else
`endif
        end
    end

    // Datapath and parameter storage; everything, weights included, clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            for (int i = 0; i < N_IN; i++) begin
                x_lat[i] <= '0;
                for (int o = 0; o < N_OUT; o++) w_mem[i][o] <= '0;
            end
            for (int o = 0; o < N_OUT; o++) begin
                b_mem[o] <= '0;
                acc[o]   <= '0;
                out_q[o] <= '0;
            end
        end else begin
            if (wr_en) begin
                for (int i = 0; i < N_IN; i++)
                    for (int o = 0; o < N_OUT; o++)
                        if (bus.w_addr == ADDR_W'(i * N_OUT + o)) w_mem[i][o] <= bus.w_data;
                for (int o = 0; o < N_OUT; o++)
                    if (bus.w_addr == ADDR_W'(N_IN * N_OUT + o)) b_mem[o] <= bus.w_data;
            end
            if (start) begin
                x_lat <= bus.input_data;
                idx   <= '0;
                for (int o = 0; o < N_OUT; o++) acc[o] <= '0;
            end
            if (state == MAC) begin
                for (int o = 0; o < N_OUT; o++) acc[o] <= acc[o] + prod[o];
                idx <= idx + IDX_W'(1);
            end
            if (state == FINAL) out_q <= res;
        end
    end
endmodule
